muller_micropipeline: RTL and testbench
=======================================

# muller_micropipeline

Clocked, parametrised two-phase (transition-signalling) Sutherland micropipeline built from a chain of DEPTH Muller C-elements, each gating a WIDTH-bit data latch. It generalises the single-C-element project into a multi-stage bundled-data FIFO, with an occupancy count and sticky protocol-violation flags. It sits inside the user project area between io-pad handshake pins and downstream async-style logic. All state is synchronous to one clock, so it is formally checkable and synthesisable without async2sync.

## Interface

- WIDTH, 8, data bits per token (≥1)
- DEPTH, 4, number of C-element stages (≥2)
- CNT_W, $clog2(DEPTH+1), width of occupancy output (derived, not overridden)

- wb_clk_i  input  1  clock
- wb_rst_i  input  1  reset: synchronous, active-high
- in_req  input  1  producer request; one token per transition
- in_data  input  WIDTH  bundled data; stable while in_req != in_ack
- in_ack  output  1  acknowledge to producer (= c[0])
- out_req  output  1  request to consumer (= c[DEPTH-1])
- out_data  output  WIDTH  data of last stage (= d[DEPTH-1])
- out_ack  input  1  consumer acknowledge; one transition per consumed token
- occupancy  output  CNT_W  tokens currently held, 0..DEPTH
- err_in  output  1  sticky: producer protocol violation
- err_out  output  1  sticky: consumer protocol violation

## Operation

- State: c[0..DEPTH-1] (1 bit each), d[0..DEPTH-1] (WIDTH each).
- C-element rule: next = (a==b) ? a : c (hold when inputs disagree).
- Stage i inputs: a = c[i-1] (in_req for i=0); b = ~c[i+1] (~out_ack for i=DEPTH-1).
- All stages evaluate on the same edge from pre-edge values; no combinational ripple between stages.
- When c[i] toggles, d[i] <= d[i-1] (in_data for i=0); else d[i] holds.
- Stage i full iff c[i] != c[i+1] (c[DEPTH] := out_ack). occupancy = popcount of full stages, registered.
- err_in sets when in_req changes while previous-cycle in_req != in_ack (second request before ack).
- err_out sets when out_ack changes while previous-cycle out_req == out_ack (ack with no pending token).
- Errors never clear except by reset; datapath behaviour is unaffected by errors.

## Timing

- Reset: c=0, d=0, occupancy=0, err_in=err_out=0; hence in_ack=0, out_req=0, out_data=0. Environment must drive in_req=out_ack=0 during reset.
- Forward latency, empty pipe, out_ack held: in_req toggle sampled at edge k → in_ack toggles at k, out_req toggles at edge k+DEPTH-1.
- Throughput: adjacent stages alternate; steady state one token per 2 cycles at either port.
- Full (occupancy=DEPTH): in_req toggle is held pending; in_ack unchanged until c[0] can fire; no token lost, no error.
- Empty: out_req == out_ack; out_data holds last delivered token.
- Simultaneous in_req and out_ack toggles on full pipe: out_ack frees last stage this edge; c[0] fires no earlier than when its downstream becomes free by the rule above.
- Reset asserted mid-operation: all tokens discarded, state as above on the next edge, regardless of in_req/out_ack.
- c-state wraps by toggling; no counters overflow.

## Structure

- Shared include muller_defs.vh: default WIDTH/DEPTH, C-element next-state function.
- Sub-module muller_c_elem: one clocked C-element (a, b, sync reset, output c), instantiated DEPTH times via generate; data latches and occupancy/error logic live in the top.

## Test plan

- Reset with in_req=1 on pins, then release with in_req=0: all outputs 0, occupancy 0, no errors.
- DEPTH=4, in_data=8'hA5, toggle in_req 0→1, out_ack held 0: in_ack=1 same edge, out_req=1 and out_data=8'hA5 three edges later, occupancy 1.
- Push 4 tokens 8'h01..8'h04 with out_ack held: occupancy 4; fifth toggle in_req stalls (in_ack unchanged); then 4 out_ack toggles return 01,02,03,04 in order and the fifth (8'h05) follows.
- Continuous streaming, producer/consumer responding immediately: 20 tokens delivered in order, one per 2 cycles, err flags 0.
- Toggle in_req twice before in_ack follows: err_in=1 and stays 1; toggle out_ack with empty pipe: err_out=1.
- Assert reset with occupancy 3: next edge occupancy 0, out_req 0, out_data 0, errors cleared.

Source files
------------

// File: rtl/muller_micropipeline_pkg.sv
// Shared defaults and the C-element next-state rule for the micropipeline.
package muller_micropipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Muller C-element: follow the inputs when they agree, otherwise hold.
  function automatic logic c_next(input logic a, input logic b, input logic c);
    return (a == b) ? a : c;
  endfunction

endpackage

// File: rtl/muller_micropipeline_c_elem.sv
// One clocked Muller C-element with synchronous active-high reset.
module muller_micropipeline_c_elem
  import muller_micropipeline_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic c
);

  // Register the C-element output; reset forces it low.
  always_ff @(posedge clk) begin
    if (rst) c <= 1'b0;
    else     c <= c_next(a, b, c);
  end

endmodule

// File: rtl/muller_micropipeline.sv
// Two-phase bundled-data micropipeline: DEPTH clocked C-elements, each gating
// a WIDTH-bit data latch, with registered occupancy and sticky protocol errors.
module muller_micropipeline
  import muller_micropipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic [CNT_W-1:0] occupancy,
  output logic             err_in,
  output logic             err_out
);

  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] a;
  logic [DEPTH-1:0] b;
  logic [DEPTH-1:0] c_nxt;
  logic [DEPTH-1:0] fire;
  logic [DEPTH-1:0] full_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];
  logic             in_req_q;
  logic             out_ack_q;

  // Stage inputs come from pre-edge neighbours only, so there is no ripple.
  assign a = {c[DEPTH-2:0], in_req};
  assign b = ~{out_ack, c[DEPTH-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      muller_micropipeline_c_elem u_c (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .a   (a[gi]),
        .b   (b[gi]),
        .c   (c[gi])
      );
    end
  endgenerate

  // Recompute the C-element decisions to know which latches capture and
  // what the post-edge fill state will be.
  always_comb begin
    c_nxt    = '0;
    fire     = '0;
    full_nxt = '0;
    cnt_nxt  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      c_nxt[i] = c_next(a[i], b[i], c[i]);
    end
    fire     = c_nxt ^ c;
    full_nxt = c_nxt ^ {out_ack, c_nxt[DEPTH-1:1]};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(full_nxt[i]);
    end
  end

  // Each latch takes its data from the previous stage (input pins for stage 0).
  always_comb begin
    d_src[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      d_src[i] = d[i-1];
    end
  end

  // Data latches capture when their C-element toggles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (fire[i]) d[i] <= d_src[i];
      end
    end
  end

  // Occupancy and sticky handshake-violation monitors.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      occupancy <= '0;
      err_in    <= 1'b0;
      err_out   <= 1'b0;
      in_req_q  <= 1'b0;
      out_ack_q <= 1'b0;
    end else begin
      occupancy <= cnt_nxt;
      err_in    <= err_in  | ((in_req ^ in_req_q) & (in_req_q ^ c[0]));
      err_out   <= err_out | ((out_ack ^ out_ack_q) & ~(out_ack_q ^ c[DEPTH-1]));
      in_req_q  <= in_req;
      out_ack_q <= out_ack;
    end
  end

  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = d[DEPTH-1];

endmodule

// File: tb/tb_muller_micropipeline.sv
// Bench for muller_micropipeline: token-flow reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_muller_micropipeline;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [CNT_W-1:0] occupancy;
  logic             err_in;
  logic             err_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  muller_micropipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .occupancy (occupancy),
    .err_in    (err_in),
    .err_out   (err_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tokens move stage to stage; a stage accepts when its
  // predecessor holds a token and it is itself empty. Last stage empties
  // when the consumer acknowledges.
  bit             m_full [DEPTH];
  bit             f      [DEPTH];
  bit             take   [DEPTH];
  logic [WIDTH-1:0] m_data [DEPTH];
  bit             m_in_ack = 0, m_out_req = 0, m_err_in = 0, m_err_out = 0;
  bit             m_prev_req = 0, m_prev_ack = 0;
  int             m_occ = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_full[i] = 0;
        m_data[i] = '0;
      end
      m_in_ack = 0; m_out_req = 0; m_err_in = 0; m_err_out = 0;
      m_prev_req = 0; m_prev_ack = 0; m_occ = 0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) f[i] = m_full[i];
      f[DEPTH-1] = (m_out_req != out_ack);
      take[0] = (in_req != m_in_ack) && !f[0];
      for (int i = 1; i < DEPTH; i++) take[i] = f[i-1] && !f[i];
      if (in_req != m_prev_req && m_prev_req != m_in_ack) m_err_in = 1;
      if (out_ack != m_prev_ack && m_prev_ack == m_out_req) m_err_out = 1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (take[i]) begin
          if (i == 0) m_data[i] = in_data;
          else        m_data[i] = m_data[i-1];
        end
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (take[i])        m_full[i] = 1;
        else if (take[i+1]) m_full[i] = 0;
      end
      if (take[0])       m_in_ack  = ~m_in_ack;
      if (take[DEPTH-1]) m_out_req = ~m_out_req;
      m_occ = (m_out_req != out_ack) ? 1 : 0;
      for (int i = 0; i < DEPTH - 1; i++) m_occ += m_full[i] ? 1 : 0;
      m_prev_req = in_req;
      m_prev_ack = out_ack;
    end
  end

  // Every cycle, compare all DUT outputs with the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ack",   in_ack,    m_in_ack);
      chk("m_out_req",  out_req,   m_out_req);
      chk("m_out_data", out_data,  m_data[DEPTH-1]);
      chk("m_occ",      occupancy, m_occ);
      chk("m_err_in",   err_in,    m_err_in);
      chk("m_err_out",  err_out,   m_err_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    bit ok = 0;
    in_data = v;
    in_req  = ~in_req;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ack == in_req) begin
        ok = 1;
        break;
      end
    end
    chk("push_ack_seen", ok, 1);
  endtask

  task automatic pop(input logic [WIDTH-1:0] exp, input string name, output int t);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_req != out_ack) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_seen"}, ok, 1);
    chk(name, out_data, exp);
    t = cyc;
    out_ack = ~out_ack;
  endtask

  initial begin
    int t, tprev;
    bit old_ack;
    rst = 1; in_req = 1; out_ack = 0; in_data = '0;
    @(negedge clk);
    cmp_en = 1;
    tick(2);
    chk("rst_in_ack", in_ack, 0);
    in_req = 0;
    rst    = 0;
    tick(2);
    chk("rel_in_ack", in_ack, 0);
    chk("rel_out_req", out_req, 0);
    chk("rel_out_data", out_data, 0);
    chk("rel_occ", occupancy, 0);
    chk("rel_errs", {err_in, err_out}, 0);

    // Single token latency through an empty pipe.
    in_data = 8'hA5;
    in_req  = 1;
    @(negedge clk);
    chk("lat_in_ack_k", in_ack, 1);
    chk("lat_out_req_k", out_req, 0);
    @(negedge clk);
    chk("lat_out_req_k1", out_req, 0);
    @(negedge clk);
    chk("lat_out_req_k2", out_req, 0);
    @(negedge clk);
    chk("lat_out_req_k3", out_req, 1);
    chk("lat_out_data", out_data, 8'hA5);
    chk("lat_occ", occupancy, 1);
    out_ack = 1;
    tick(2);
    chk("lat_drained", occupancy, 0);

    // Fill to capacity, stall the fifth token, then drain in order.
    for (int i = 1; i <= 4; i++) push(8'(i));
    tick(4);
    chk("full_occ", occupancy, 4);
    old_ack = in_ack;
    in_data = 8'h05;
    in_req  = ~in_req;
    tick(4);
    chk("stall_ack", in_ack, old_ack);
    chk("stall_occ", occupancy, 4);
    chk("stall_err", err_in, 0);
    for (int i = 1; i <= 5; i++) pop(8'(i), "fifo_order", t);
    tick(8);
    chk("fifo_empty", occupancy, 0);

    // Streaming with immediate responses on both sides.
    fork
      begin
        for (int i = 0; i < 20; i++) push(8'(8'h10 + i));
      end
      begin
        tprev = 0;
        for (int i = 0; i < 20; i++) begin
          pop(8'(8'h10 + i), "stream_data", t);
          if (i > 0) chk("stream_gap", t - tprev, 2);
          tprev = t;
        end
      end
    join
    tick(6);
    chk("stream_errs", {err_in, err_out}, 0);
    chk("stream_occ", occupancy, 0);

    // Producer violation: two request transitions while stage 0 is blocked.
    for (int i = 1; i <= 4; i++) push(8'(8'h30 + i));
    tick(4);
    in_data = 8'h35;
    in_req  = ~in_req;
    @(negedge clk);
    in_req  = ~in_req;
    @(negedge clk);
    chk("err_in_set", err_in, 1);
    tick(3);
    chk("err_in_sticky", err_in, 1);
    for (int i = 1; i <= 4; i++) pop(8'(8'h30 + i), "err_drain", t);
    tick(6);
    chk("err_out_clear", err_out, 0);
    out_ack = ~out_ack;
    @(negedge clk);
    @(negedge clk);
    chk("err_out_set", err_out, 1);
    chk("err_in_still", err_in, 1);

    // Reset with three tokens resident.
    rst = 1; in_req = 0; out_ack = 0;
    tick(2);
    rst = 0;
    tick(1);
    for (int i = 1; i <= 3; i++) push(8'(8'h40 + i));
    tick(5);
    chk("pre_rst_occ", occupancy, 3);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_out_req", out_req, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_errs", {err_in, err_out}, 0);
    in_req = 0; out_ack = 0;
    tick(2);
    rst = 0;
    tick(3);
    chk("final_idle", {in_ack, out_req, occupancy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
